// File: rtl/ad_scan_seq.sv
// Channel-scanning sequencer for the external serial ADC: per channel it settles the mux,
// pulses CNVST, waits on BUSY, shifts the result in MSB first and publishes it with a strobe.
module ad_scan_seq #(
  parameter int NUM_CH     = 16,
  parameter int DATA_W     = 16,
  parameter int SETTLE_CYC = 20,
  parameter int CNV_CYC    = 3,
  parameter int SCLK_HALF  = 2,
  parameter int BUSY_TMO   = 255
) (
  input  logic              SYSCLK,
  input  logic              RESET,
  input  logic              SCAN_EN,
  input  logic              AD_BUSY,
  input  logic              AD_SDOUT,
  output logic              AD_CNVST,
  output logic              AD_SCLK,
  output logic [2:0]        AD_MUX,
  output logic              AD_SEL,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [3:0]        CH_OUT,
  output logic              DATA_VALID,
  output logic              SCAN_DONE,
  output logic              TMO_ERR
);

  typedef enum logic [2:0] {IDLE, SETTLE, CONVST, WAIT_BUSY, SHIFT, STORE} state_t;

  localparam int MAX_A = (SETTLE_CYC > CNV_CYC) ? SETTLE_CYC : CNV_CYC;
  localparam int MAX_B = (BUSY_TMO > SCLK_HALF) ? BUSY_TMO : SCLK_HALF;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = ($clog2(MAX_C + 1) < 2) ? 2 : $clog2(MAX_C + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNV_LAST    = CNT_W'(CNV_CYC - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST   = CNT_W'(BUSY_TMO - 1);
  localparam logic [CNT_W-1:0] HALF_LAST   = CNT_W'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] BUSY_IGN    = CNT_W'(2);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_W - 1);
  localparam logic [3:0]       CH_LAST     = 4'(NUM_CH - 1);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic                phase;
  logic [BIT_W-1:0]    bcnt;
  logic [DATA_W-1:0]   sr;
  logic [3:0]          ch;
  logic                discard;
  logic                half_end, busy_done, busy_tmo, shift_done;

  always_comb begin
    half_end   = (cnt == HALF_LAST);
    // BUSY is ignored for the first two wait cycles to cover the ADC's rise latency
    busy_done  = (state == WAIT_BUSY) && (cnt >= BUSY_IGN) && !AD_BUSY;
    busy_tmo   = (state == WAIT_BUSY) && (cnt == BUSY_LAST) && !busy_done;
    shift_done = (state == SHIFT) && half_end && phase && (bcnt == BIT_LAST);
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (SCAN_EN) state_nx = SETTLE;
      SETTLE:    if (cnt == SETTLE_LAST) state_nx = CONVST;
      CONVST:    if (cnt == CNV_LAST) state_nx = WAIT_BUSY;
      WAIT_BUSY: if (busy_done) state_nx = SHIFT;
                 else if (busy_tmo) state_nx = STORE;
      SHIFT:     if (shift_done) state_nx = STORE;
      STORE:     state_nx = SCAN_EN ? SETTLE : IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    AD_CNVST = (state == CONVST);
    AD_SCLK  = (state == SHIFT) && phase;
    AD_MUX   = ch[2:0];
    AD_SEL   = ch[3];
  end

  // One counter serves every state; in SHIFT it times half-periods of AD_SCLK
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      cnt     <= '0;
      phase   <= 1'b0;
      bcnt    <= '0;
      sr      <= '0;
      ch      <= '0;
      discard <= 1'b0;
    end else begin
      if (state_nx != state) begin
        cnt   <= '0;
        phase <= 1'b0;
        bcnt  <= '0;
      end else if ((state == SHIFT) && half_end) begin
        cnt   <= '0;
        phase <= ~phase;
        if (phase) bcnt <= bcnt + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if ((state == SHIFT) && half_end && !phase) sr <= {sr[DATA_W-2:0], AD_SDOUT};
      if (busy_tmo)            discard <= 1'b1;
      else if (state == STORE) discard <= 1'b0;
      if (state == STORE) ch <= (ch == CH_LAST) ? 4'd0 : ch + 4'd1;
    end
  end

  // Published outputs update together, so the strobe lines up with the new sample
  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      DATA_OUT   <= '0;
      CH_OUT     <= '0;
      DATA_VALID <= 1'b0;
      SCAN_DONE  <= 1'b0;
      TMO_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      SCAN_DONE  <= 1'b0;
      if ((state == STORE) && !discard) begin
        DATA_OUT   <= sr;
        CH_OUT     <= ch;
        DATA_VALID <= 1'b1;
        SCAN_DONE  <= (ch == CH_LAST);
      end
      if (busy_tmo) TMO_ERR <= 1'b1;
    end
  end

endmodule
